// File: rtl/display_pkg.sv
// Shared constants for the BCD 7-segment scan display.
// Segment patterns are active-high and ordered {g,f,e,d,c,b,a}.
package display_pkg;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   // Digit slot indices; these double as the scan state encodings.
   localparam logic [1:0] DIG_ONES  = 2'd0;
   localparam logic [1:0] DIG_TENS  = 2'd1;
   localparam logic [1:0] DIG_HUNDS = 2'd2;

   typedef enum logic [1:0] {
      StOnes  = 2'd0,
      StTens  = 2'd1,
      StHunds = 2'd2
   } scan_state_e;

   // Active-high anode enable {hundreds,tens,ones} for a digit slot.
   function automatic logic [2:0] dig_onehot(logic [1:0] idx);
      logic [2:0] oh;
      oh = 3'b000;
      case (idx)
         DIG_ONES:  oh = 3'b001;
         DIG_TENS:  oh = 3'b010;
         DIG_HUNDS: oh = 3'b100;
         default:   oh = 3'b001;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; non-BCD values show a dash.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Standard digit patterns, dash for 10..15.
   always_comb begin
      seg_o = SEG_DASH;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_7seg_scan.sv
// 3-digit multiplexed 7-segment driver with frame-synchronous double buffering.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading-zero hundreds/tens digits).
module bcd_7seg_scan #(
   parameter int unsigned REFRESH_DIV    = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame_done
);
   import display_pkg::*;

   localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(REFRESH_DIV - 1);

   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   scan_state_e     state_q, state_d;
   logic [11:0]     shadow_q, shadow_d;
   logic [11:0]     active_q, active_d;
   logic            pending_q, pending_d;
   logic [6:0]      seg_q, seg_d;
   logic [2:0]      an_q, an_d;
   logic            frame_done_q;

   logic       tick;
   logic       boundary;
   logic [3:0] digit;
   logic       blank;
   logic [6:0] dec_seg;

   assign tick     = (div_cnt_q == DivMax);
   assign boundary = tick && (state_q == StHunds);

   // Refresh divider: free-running 0..REFRESH_DIV-1.
   always_comb begin
      div_cnt_d = tick ? '0 : div_cnt_q + DivW'(1);
   end

   // Scan FSM next state: advance one digit slot per tick.
   always_comb begin
      state_d = state_q;
      if (tick) begin
         case (state_q)
            StOnes:  state_d = StTens;
            StTens:  state_d = StHunds;
            StHunds: state_d = StOnes;
            default: state_d = StOnes;
         endcase
      end
   end

   // Double buffer: a pending shadow moves to active only at a frame boundary.
   // A load on the boundary cycle itself is kept pending for the following frame.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (boundary && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (load) begin
         shadow_d  = {hundreds, tens, ones};
         pending_d = 1'b1;
      end
   end

   // Select the digit for the current slot and decide whether it is blanked.
   always_comb begin
      digit = active_q[3:0];
      blank = 1'b0;
      case (state_q)
         StTens: begin
            digit = active_q[7:4];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (active_q[11:8] == 4'd0) && (active_q[7:4] == 4'd0);
`endif
         end
         StHunds: begin
            digit = active_q[11:8];
`ifdef LEADING_ZERO_BLANK_EN
            blank = (active_q[11:8] == 4'd0);
`endif
         end
         default: digit = active_q[3:0];
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd_i (digit),
      .seg_o (dec_seg)
   );

   // Next registered outputs, active-high; blanked slots keep anode and segments off.
   always_comb begin
      seg_d = blank ? SEG_OFF : dec_seg;
      an_d  = blank ? 3'b000 : dig_onehot(state_q);
   end

   // State, buffers and registered display outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q    <= '0;
         state_q      <= StOnes;
         shadow_q     <= '0;
         active_q     <= '0;
         pending_q    <= 1'b0;
         seg_q        <= SEG_OFF;
         an_q         <= 3'b000;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         state_q      <= state_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= boundary;
      end
   end

   assign seg        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
   assign an         = SEG_ACTIVE_LOW ? ~an_q : an_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Directed bench for bcd_7seg_scan with REFRESH_DIV=4 and active-low outputs.
// Expected values follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_bcd_7seg_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       load;
   logic [3:0] hundreds, tens, ones;
   logic [6:0] seg;
   logic [2:0] an;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   // Active-low anode patterns {hundreds,tens,ones}
   localparam logic [2:0] AH = 3'b011;
   localparam logic [2:0] AT = 3'b101;
   localparam logic [2:0] AO = 3'b110;
   localparam logic [2:0] AX = 3'b111;

   typedef struct {
      logic [11:0] val;
      logic [6:0]  sh, st, so;
      logic [2:0]  ah, at, ao;
   } vec_t;

   vec_t tab[6];
   vec_t cur, zero_v, v888, v999, v123, v456;

   always #5 clk = ~clk;

   bcd_7seg_scan #(
      .REFRESH_DIV    (4),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .hundreds   (hundreds),
      .tens       (tens),
      .ones       (ones),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   function automatic vec_t mk(logic [11:0] val, logic [6:0] sh, logic [6:0] st,
                               logic [6:0] so, logic [2:0] ah, logic [2:0] at,
                               logic [2:0] ao);
      vec_t v;
      v.val = val;
      v.sh = sh; v.st = st; v.so = so;
      v.ah = ah; v.at = at; v.ao = ao;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one 12-cycle frame from a frame-aligned negedge, checking each slot.
   // ldN_at = k drives load for the edge ending cycle k (12 = boundary tick).
   task automatic run_frame(string name, vec_t e, int ld1_at, logic [11:0] ld1,
                            int ld2_at, logic [11:0] ld2);
      for (int i = 1; i <= 12; i++) begin
         load = 1'b0;
         if (i == ld1_at) begin
            load = 1'b1;
            {hundreds, tens, ones} = ld1;
         end else if (i == ld2_at) begin
            load = 1'b1;
            {hundreds, tens, ones} = ld2;
         end
         cycle();
         load = 1'b0;
         if (i <= 4) begin
            chk($sformatf("%s c%0d an_ones", name, i), 32'(an), 32'(e.ao));
            chk($sformatf("%s c%0d seg_ones", name, i), 32'(seg), 32'(e.so));
         end else if (i <= 8) begin
            chk($sformatf("%s c%0d an_tens", name, i), 32'(an), 32'(e.at));
            chk($sformatf("%s c%0d seg_tens", name, i), 32'(seg), 32'(e.st));
         end else begin
            chk($sformatf("%s c%0d an_hunds", name, i), 32'(an), 32'(e.ah));
            chk($sformatf("%s c%0d seg_hunds", name, i), 32'(seg), 32'(e.sh));
         end
         chk($sformatf("%s c%0d frame_done", name, i), 32'(frame_done), 32'(i == 12));
      end
   endtask

   initial begin
`ifdef LEADING_ZERO_BLANK_EN
      zero_v = mk(12'h000, 7'h7F, 7'h7F, 7'h40, AX, AX, AO);
      tab[2] = mk(12'h007, 7'h7F, 7'h7F, 7'h78, AX, AX, AO);
      tab[4] = mk(12'h050, 7'h7F, 7'h12, 7'h40, AX, AT, AO);
`else
      zero_v = mk(12'h000, 7'h40, 7'h40, 7'h40, AH, AT, AO);
      tab[2] = mk(12'h007, 7'h40, 7'h40, 7'h78, AH, AT, AO);
      tab[4] = mk(12'h050, 7'h40, 7'h12, 7'h40, AH, AT, AO);
`endif
      tab[0] = mk(12'h123, 7'h79, 7'h24, 7'h30, AH, AT, AO);
      tab[1] = mk(12'h25C, 7'h24, 7'h12, 7'h3F, AH, AT, AO);
      tab[3] = zero_v;
      tab[5] = mk(12'h980, 7'h10, 7'h00, 7'h40, AH, AT, AO);
      v888   = mk(12'h888, 7'h00, 7'h00, 7'h00, AH, AT, AO);
      v999   = mk(12'h999, 7'h10, 7'h10, 7'h10, AH, AT, AO);
      v123   = tab[0];
      v456   = mk(12'h456, 7'h19, 7'h12, 7'h02, AH, AT, AO);

      rst = 1'b1;
      load = 1'b0;
      {hundreds, tens, ones} = 12'h000;
      #1;
      chk("reset seg", 32'(seg), 32'h7F);
      chk("reset an", 32'(an), 32'(AX));
      chk("reset frame_done", 32'(frame_done), 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("release an", 32'(an), 32'(AX));
      chk("release seg", 32'(seg), 32'h7F);
      run_frame("post_reset", zero_v, 0, 12'h0, 0, 12'h0);

      // Each load must not disturb the current frame and must show in the next.
      cur = zero_v;
      for (int v = 0; v < 6; v++) begin
         run_frame($sformatf("tab%0d_old", v), cur, 5, tab[v].val, 0, 12'h0);
         cur = tab[v];
      end
      run_frame("tab_last", cur, 0, 12'h0, 0, 12'h0);

      // Two loads in one frame: only the later value is ever shown.
      run_frame("two_loads", cur, 2, v888.val, 7, v999.val);
      run_frame("show_999", v999, 0, 12'h0, 0, 12'h0);
      run_frame("hold_999", v999, 0, 12'h0, 0, 12'h0);

      // Load coincident with the boundary tick lands one frame later.
      run_frame("coinc_cur", v999, 3, v123.val, 12, v456.val);
      run_frame("coinc_next", v123, 0, 12'h0, 0, 12'h0);
      run_frame("coinc_after", v456, 0, 12'h0, 0, 12'h0);

      // Reset in the middle of the tens slot.
      repeat (6) cycle();
      chk("pre_reset an_tens", 32'(an), 32'(AT));
      rst = 1'b1;
      #1;
      chk("midscan seg", 32'(seg), 32'h7F);
      chk("midscan an", 32'(an), 32'(AX));
      chk("midscan frame_done", 32'(frame_done), 32'h0);
      @(negedge clk);
      cycle();
      rst = 1'b0;
      run_frame("midscan_restart", zero_v, 0, 12'h0, 0, 12'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
